// File: rtl/pcm_seq_pkg.sv
// Shared definitions for the PCM channel sequencer: FSM states, register map
// constants and byte-lane helpers used by the CPU write path.
package pcm_seq_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ACCUM = 2'd1,
        ST_FETCH = 2'd2,
        ST_NEXT  = 2'd3
    } seq_state_e;

    // Per-channel register offsets inside a 0x20-byte channel window
    localparam logic [4:0] OFS_PITCH = 5'h00;
    localparam logic [4:0] OFS_START = 5'h04;
    localparam logic [4:0] OFS_LOOP  = 5'h08;
    localparam logic [4:0] OFS_END   = 5'h0C;

    localparam logic [9:0] CTRL_BASE   = 10'h200;
    localparam logic [9:0] KEYON_ADDR  = 10'h214;
    localparam logic [9:0] KEYOFF_ADDR = 10'h215;

    // Mask of the byte lane selected inside a 24-bit little-endian field
    function automatic logic [23:0] lane_mask(input logic [1:0] lane);
        return 24'h0000FF << {lane, 3'b000};
    endfunction

    // Write byte shifted into its lane of a 24-bit little-endian field
    function automatic logic [23:0] lane_data(input logic [1:0] lane, input logic [7:0] data);
        return {16'h0000, data} << {lane, 3'b000};
    endfunction

endpackage

// File: rtl/bus_write_sync.sv
// CPU write-port synchroniser: brings NCS/NWR/address/data into the CLK
// domain through two flops each and emits a single-cycle commit on the
// synchronised rising edge of NWR while NCS is low.
//   clk, rst         : system clock, async active-high reset
//   ncs, nwr         : asynchronous CPU strobes (active low)
//   ab, db_in        : asynchronous CPU address / data
//   wr_en            : one-cycle commit pulse (registered)
//   wr_addr, wr_data : address / data captured on the commit edge
module bus_write_sync (
    input  logic       clk,
    input  logic       rst,
    input  logic       ncs,
    input  logic       nwr,
    input  logic [9:0] ab,
    input  logic [7:0] db_in,
    output logic       wr_en,
    output logic [9:0] wr_addr,
    output logic [7:0] wr_data
);

    logic [1:0] ncs_sync;
    logic [1:0] nwr_sync;
    logic       nwr_prev;
    logic [9:0] ab_s1, ab_s2;
    logic [7:0] db_s1, db_s2;
    logic       commit_c;

    // Strobes idle high out of reset so no phantom edge is seen on release
    assign commit_c = nwr_sync[1] & ~nwr_prev & ~ncs_sync[1];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ncs_sync <= 2'b11;
            nwr_sync <= 2'b11;
            nwr_prev <= 1'b1;
            ab_s1    <= '0;
            ab_s2    <= '0;
            db_s1    <= '0;
            db_s2    <= '0;
            wr_en    <= 1'b0;
            wr_addr  <= '0;
            wr_data  <= '0;
        end else begin
            ncs_sync <= {ncs_sync[0], ncs};
            nwr_sync <= {nwr_sync[0], nwr};
            nwr_prev <= nwr_sync[1];
            ab_s1    <= ab;
            ab_s2    <= ab_s1;
            db_s1    <= db_in;
            db_s2    <= db_s1;
            wr_en    <= commit_c;
            if (commit_c) begin
                wr_addr <= ab_s2;
                wr_data <= db_s2;
            end
        end
    end

endmodule

// File: rtl/pcm_channel_sequencer.sv
// Time-multiplexed PCM channel address sequencer. On each TICK every active
// channel is visited in order: its fixed-point position is stepped by pitch,
// loop/stop is applied at the end address and one ROM fetch is handshaked.
//   CLK, RES          : clock, async active-high reset
//   NCS, NWR, AB, DB_IN : asynchronous 8-bit CPU write port
//   TICK              : sample-rate pulse
//   RA, RA_REQ, RA_ACK : sample ROM fetch handshake
//   CH_ID             : channel being fetched
//   CH_ACTIVE         : per-channel playing flags
//   BUSY, OVR         : scan in progress / sticky tick overrun
// Build option: define REVERSE_EN to let control bit1 play channels backwards.
module pcm_channel_sequencer
    import pcm_seq_pkg::*;
#(
    parameter int unsigned CHANNELS = 8,
    parameter int unsigned ADDR_W   = 24,
    parameter int unsigned PITCH_W  = 16,
    parameter int unsigned FRAC_W   = 12
) (
    input  logic                CLK,
    input  logic                RES,
    input  logic                NCS,
    input  logic                NWR,
    input  logic [9:0]          AB,
    input  logic [7:0]          DB_IN,
    input  logic                TICK,
    output logic [ADDR_W-1:0]   RA,
    output logic                RA_REQ,
    input  logic                RA_ACK,
    output logic [3:0]          CH_ID,
    output logic [CHANNELS-1:0] CH_ACTIVE,
    output logic                BUSY,
    output logic                OVR
);

    localparam int unsigned POS_W = ADDR_W + FRAC_W;

    // CPU write path
    logic       wr_en;
    logic [9:0] wr_addr;
    logic [7:0] wr_data;

    bus_write_sync u_bus_write_sync (
        .clk     (CLK),
        .rst     (RES),
        .ncs     (NCS),
        .nwr     (NWR),
        .ab      (AB),
        .db_in   (DB_IN),
        .wr_en   (wr_en),
        .wr_addr (wr_addr),
        .wr_data (wr_data)
    );

    // Channel register file and playback state
    logic [PITCH_W-1:0] pitch_r [CHANNELS];
    logic [ADDR_W-1:0]  start_r [CHANNELS];
    logic [ADDR_W-1:0]  loop_r  [CHANNELS];
    logic [ADDR_W-1:0]  end_r   [CHANNELS];
    logic [POS_W-1:0]   pos_r   [CHANNELS];
    logic [CHANNELS-1:0] loop_en_r, rev_r, active_r, fresh_r;
    logic [CHANNELS-1:0] pend_on, pend_off;

    // Sequencer registers
    seq_state_e        state_q, state_d;
    logic [3:0]        ch_q, ch_d;
    logic              busy_q, busy_d;
    logic              req_q, req_d;
    logic [ADDR_W-1:0] ra_q, ra_d;
    logic [3:0]        chid_q, chid_d;
    logic              ovr_q;

    // Write decode
    logic [3:0] wr_ch;
    logic [4:0] wr_ofs;
    logic [1:0] wr_lane;
    logic       wr_chan_space, wr_pitch, wr_start, wr_loop, wr_end;
    logic       wr_ctrl, wr_keyon, wr_keyoff;
    logic [PITCH_W-1:0] pitch_mask, pitch_data;
    logic [ADDR_W-1:0]  addr_mask, addr_data;

    always_comb begin
        wr_ch         = wr_addr[9] ? wr_addr[3:0] : wr_addr[8:5];
        wr_ofs        = wr_addr[4:0];
        wr_lane       = wr_ofs[1:0];
        wr_chan_space = wr_en & ~wr_addr[9] & ~wr_ofs[4];
        wr_pitch      = wr_chan_space & (wr_ofs[3:2] == OFS_PITCH[3:2]) & ~wr_lane[1];
        wr_start      = wr_chan_space & (wr_ofs[3:2] == OFS_START[3:2]) & (wr_lane != 2'd3);
        wr_loop       = wr_chan_space & (wr_ofs[3:2] == OFS_LOOP[3:2])  & (wr_lane != 2'd3);
        wr_end        = wr_chan_space & (wr_ofs[3:2] == OFS_END[3:2])   & (wr_lane != 2'd3);
        wr_ctrl       = wr_en & (wr_addr[9:4] == CTRL_BASE[9:4]);
        wr_keyon      = wr_en & (wr_addr == KEYON_ADDR);
        wr_keyoff     = wr_en & (wr_addr == KEYOFF_ADDR);
        pitch_mask    = PITCH_W'(lane_mask(wr_lane));
        pitch_data    = PITCH_W'(lane_data(wr_lane, wr_data));
        addr_mask     = ADDR_W'(lane_mask(wr_lane));
        addr_data     = ADDR_W'(lane_data(wr_lane, wr_data));
    end

    // Select the channel currently being serviced
    logic [POS_W-1:0]   cur_pos;
    logic [PITCH_W-1:0] cur_pitch;
    logic [ADDR_W-1:0]  cur_end, cur_loop;
    logic               cur_loop_en, cur_active, cur_fresh, cur_rev;

    always_comb begin
        cur_pos     = '0;
        cur_pitch   = '0;
        cur_end     = '0;
        cur_loop    = '0;
        cur_loop_en = 1'b0;
        cur_active  = 1'b0;
        cur_fresh   = 1'b0;
        cur_rev     = 1'b0;
        for (int c = 0; c < CHANNELS; c++) begin
            if (ch_q == 4'(c)) begin
                cur_pos     = pos_r[c];
                cur_pitch   = pitch_r[c];
                cur_end     = end_r[c];
                cur_loop    = loop_r[c];
                cur_loop_en = loop_en_r[c];
                cur_active  = active_r[c];
                cur_fresh   = fresh_r[c];
                cur_rev     = rev_r[c];
            end
        end
    end

    // Position step and end-of-sample test
    logic [POS_W-1:0]  step_pos;
    logic [ADDR_W-1:0] step_int;
    logic              past_end;

`ifdef REVERSE_EN
    always_comb begin
        step_pos = cur_rev ? (cur_pos - POS_W'(cur_pitch)) : (cur_pos + POS_W'(cur_pitch));
        step_int = step_pos[POS_W-1:FRAC_W];
        past_end = cur_rev ? (step_int < cur_end) : (step_int > cur_end);
    end
`else
    logic unused_rev_c;
    assign unused_rev_c = cur_rev;

    always_comb begin
        step_pos = cur_pos + POS_W'(cur_pitch);
        step_int = step_pos[POS_W-1:FRAC_W];
        past_end = step_int > cur_end;
    end
`endif

    // Next-state and output logic
    logic             apply_keys, pos_we, stop_ch, clr_fresh;
    logic [POS_W-1:0] pos_wdata;

    always_comb begin
        state_d    = state_q;
        ch_d       = ch_q;
        busy_d     = busy_q;
        req_d      = req_q;
        ra_d       = ra_q;
        chid_d     = chid_q;
        apply_keys = 1'b0;
        pos_we     = 1'b0;
        pos_wdata  = '0;
        stop_ch    = 1'b0;
        clr_fresh  = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (TICK) begin
                    apply_keys = 1'b1;
                    busy_d     = 1'b1;
                    ch_d       = 4'd0;
                    state_d    = ST_ACCUM;
                end
            end
            ST_ACCUM: begin
                if (!cur_active) begin
                    state_d = ST_NEXT;
                end else if (cur_fresh) begin
                    // First visit after key-on fetches the start address as-is
                    clr_fresh = 1'b1;
                    ra_d      = cur_pos[POS_W-1:FRAC_W];
                    req_d     = 1'b1;
                    chid_d    = ch_q;
                    state_d   = ST_FETCH;
                end else if (past_end && !cur_loop_en) begin
                    stop_ch = 1'b1;
                    state_d = ST_NEXT;
                end else begin
                    pos_we    = 1'b1;
                    pos_wdata = past_end ? {cur_loop, step_pos[FRAC_W-1:0]} : step_pos;
                    ra_d      = pos_wdata[POS_W-1:FRAC_W];
                    req_d     = 1'b1;
                    chid_d    = ch_q;
                    state_d   = ST_FETCH;
                end
            end
            ST_FETCH: begin
                if (RA_ACK) begin
                    req_d   = 1'b0;
                    state_d = ST_NEXT;
                end
            end
            ST_NEXT: begin
                if (ch_q == 4'(CHANNELS - 1)) begin
                    busy_d  = 1'b0;
                    state_d = ST_IDLE;
                end else begin
                    ch_d    = ch_q + 4'd1;
                    state_d = ST_ACCUM;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // State register and registered outputs
    always_ff @(posedge CLK or posedge RES) begin
        if (RES) begin
            state_q <= ST_IDLE;
            ch_q    <= '0;
            busy_q  <= 1'b0;
            req_q   <= 1'b0;
            ra_q    <= '0;
            chid_q  <= '0;
            ovr_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            ch_q    <= ch_d;
            busy_q  <= busy_d;
            req_q   <= req_d;
            ra_q    <= ra_d;
            chid_q  <= chid_d;
            if (TICK && busy_q) ovr_q <= 1'b1;
        end
    end

    // Pending key masks accumulate until the next scan starts
    always_ff @(posedge CLK or posedge RES) begin
        if (RES) begin
            pend_on  <= '0;
            pend_off <= '0;
        end else begin
            if (apply_keys) pend_on <= wr_keyon ? CHANNELS'(wr_data) : '0;
            else if (wr_keyon) pend_on <= pend_on | CHANNELS'(wr_data);
            if (apply_keys) pend_off <= wr_keyoff ? CHANNELS'(wr_data) : '0;
            else if (wr_keyoff) pend_off <= pend_off | CHANNELS'(wr_data);
        end
    end

    // Channel registers, key application and per-channel playback state
    always_ff @(posedge CLK or posedge RES) begin
        if (RES) begin
            for (int c = 0; c < CHANNELS; c++) begin
                pitch_r[c] <= '0;
                start_r[c] <= '0;
                loop_r[c]  <= '0;
                end_r[c]   <= '0;
                pos_r[c]   <= '0;
            end
            loop_en_r <= '0;
            rev_r     <= '0;
            active_r  <= '0;
            fresh_r   <= '0;
        end else begin
            for (int c = 0; c < CHANNELS; c++) begin
                if (wr_pitch && wr_ch == 4'(c))
                    pitch_r[c] <= (pitch_r[c] & ~pitch_mask) | (pitch_data & pitch_mask);
                if (wr_start && wr_ch == 4'(c))
                    start_r[c] <= (start_r[c] & ~addr_mask) | (addr_data & addr_mask);
                if (wr_loop && wr_ch == 4'(c))
                    loop_r[c] <= (loop_r[c] & ~addr_mask) | (addr_data & addr_mask);
                if (wr_end && wr_ch == 4'(c))
                    end_r[c] <= (end_r[c] & ~addr_mask) | (addr_data & addr_mask);
                if (wr_ctrl && wr_ch == 4'(c)) begin
                    loop_en_r[c] <= wr_data[0];
                    rev_r[c]     <= wr_data[1];
                end

                // Key-off takes priority over a simultaneous key-on
                if (apply_keys && pend_off[c]) begin
                    active_r[c] <= 1'b0;
                end else if (apply_keys && pend_on[c]) begin
                    active_r[c] <= 1'b1;
                    fresh_r[c]  <= 1'b1;
                    pos_r[c]    <= {start_r[c], {FRAC_W{1'b0}}};
                end else if (ch_q == 4'(c)) begin
                    if (stop_ch)   active_r[c] <= 1'b0;
                    if (clr_fresh) fresh_r[c]  <= 1'b0;
                    if (pos_we)    pos_r[c]    <= pos_wdata;
                end
            end
        end
    end

    assign RA        = ra_q;
    assign RA_REQ    = req_q;
    assign CH_ID     = chid_q;
    assign CH_ACTIVE = active_r;
    assign BUSY      = busy_q;
    assign OVR       = ovr_q;

endmodule

// File: tb/tb_pcm_channel_sequencer.sv
// Directed self-checking bench for pcm_channel_sequencer (default parameters).
module tb_pcm_channel_sequencer;

    logic        CLK = 1'b0;
    logic        RES = 1'b1;
    logic        NCS = 1'b1;
    logic        NWR = 1'b1;
    logic [9:0]  AB = '0;
    logic [7:0]  DB_IN = '0;
    logic        TICK = 1'b0;
    logic [23:0] RA;
    logic        RA_REQ;
    logic        RA_ACK = 1'b1;
    logic [3:0]  CH_ID;
    logic [7:0]  CH_ACTIVE;
    logic        BUSY;
    logic        OVR;

    int n_checks = 0;
    int n_pass   = 0;

    logic [23:0] fetch_ra [$];
    logic [3:0]  fetch_ch [$];

    pcm_channel_sequencer dut (
        .CLK       (CLK),
        .RES       (RES),
        .NCS       (NCS),
        .NWR       (NWR),
        .AB        (AB),
        .DB_IN     (DB_IN),
        .TICK      (TICK),
        .RA        (RA),
        .RA_REQ    (RA_REQ),
        .RA_ACK    (RA_ACK),
        .CH_ID     (CH_ID),
        .CH_ACTIVE (CH_ACTIVE),
        .BUSY      (BUSY),
        .OVR       (OVR)
    );

    always #5 CLK = ~CLK;

    // Log every completed fetch handshake
    always @(posedge CLK) begin
        if (RA_REQ && RA_ACK) begin
            fetch_ra.push_back(RA);
            fetch_ch.push_back(CH_ID);
        end
    end

    task automatic do_reset();
        @(negedge CLK);
        RES = 1'b1; TICK = 1'b0; NCS = 1'b1; NWR = 1'b1; RA_ACK = 1'b1;
        repeat (2) @(negedge CLK);
        RES = 1'b0;
        repeat (2) @(negedge CLK);
        fetch_ra.delete();
        fetch_ch.delete();
    endtask

    task automatic wr_reg(input logic [9:0] a, input logic [7:0] d);
        @(negedge CLK);
        NCS = 1'b0; AB = a; DB_IN = d; NWR = 1'b0;
        repeat (3) @(negedge CLK);
        NWR = 1'b1;
        repeat (4) @(negedge CLK);
        NCS = 1'b1;
        repeat (2) @(negedge CLK);
    endtask

    task automatic prog_ch(input int ch, input logic [15:0] pitch, input logic [23:0] st,
                           input logic [23:0] lp, input logic [23:0] en, input logic [7:0] ctrl);
        logic [9:0] b;
        b = 10'(ch * 32);
        wr_reg(b + 10'h00, pitch[7:0]);
        wr_reg(b + 10'h01, pitch[15:8]);
        wr_reg(b + 10'h04, st[7:0]);
        wr_reg(b + 10'h05, st[15:8]);
        wr_reg(b + 10'h06, st[23:16]);
        wr_reg(b + 10'h08, lp[7:0]);
        wr_reg(b + 10'h09, lp[15:8]);
        wr_reg(b + 10'h0A, lp[23:16]);
        wr_reg(b + 10'h0C, en[7:0]);
        wr_reg(b + 10'h0D, en[15:8]);
        wr_reg(b + 10'h0E, en[23:16]);
        wr_reg(10'h200 + 10'(ch), ctrl);
    endtask

    task automatic pulse_tick();
        @(negedge CLK);
        TICK = 1'b1;
        @(negedge CLK);
        TICK = 1'b0;
    endtask

    task automatic wait_idle();
        int i;
        i = 0;
        while (BUSY && i < 300) begin
            @(negedge CLK);
            i++;
        end
        n_checks++;
        if (BUSY !== 1'b0) $display("FAIL scan_end: BUSY=%b after %0d cycles, expected 0", BUSY, i);
        else n_pass++;
    endtask

    task automatic wait_req();
        int i;
        i = 0;
        while (RA_REQ !== 1'b1 && i < 100) begin
            @(negedge CLK);
            i++;
        end
        n_checks++;
        if (RA_REQ !== 1'b1) $display("FAIL req_wait: RA_REQ=%b after %0d cycles, expected 1", RA_REQ, i);
        else n_pass++;
    endtask

    task automatic test_reset();
        logic [38:0] got;
        got = {RA, RA_REQ, CH_ID, CH_ACTIVE, BUSY, OVR};
        n_checks++;
        if (got !== 39'd0) $display("FAIL reset_outputs: got %h, expected 0", got);
        else n_pass++;
    endtask

    task automatic test_one_shot();
        logic [23:0] exp_ra [4];
        exp_ra = '{24'h100, 24'h101, 24'h102, 24'h103};
        do_reset();
        prog_ch(0, 16'h1000, 24'h000100, 24'h000000, 24'h000103, 8'h00);
        wr_reg(10'h214, 8'h01);
        repeat (5) begin pulse_tick(); wait_idle(); end
        n_checks++;
        if (fetch_ra.size() != 4) $display("FAIL oneshot_count: got %0d fetches, expected 4", fetch_ra.size());
        else n_pass++;
        for (int i = 0; i < 4; i++) begin
            if (i < fetch_ra.size()) begin
                n_checks++;
                if (fetch_ra[i] !== exp_ra[i] || fetch_ch[i] !== 4'd0)
                    $display("FAIL oneshot_ra%0d: got ch%0d RA=%h, expected ch0 RA=%h", i, fetch_ch[i], fetch_ra[i], exp_ra[i]);
                else n_pass++;
            end
        end
        n_checks++;
        if (CH_ACTIVE !== 8'h00) $display("FAIL oneshot_stop: CH_ACTIVE=%h, expected 00", CH_ACTIVE);
        else n_pass++;
    endtask

    task automatic test_loop();
        logic [23:0] exp_ra [6];
        exp_ra = '{24'h100, 24'h101, 24'h102, 24'h103, 24'h080, 24'h081};
        do_reset();
        prog_ch(0, 16'h1000, 24'h000100, 24'h000080, 24'h000103, 8'h01);
        wr_reg(10'h214, 8'h01);
        repeat (6) begin pulse_tick(); wait_idle(); end
        n_checks++;
        if (fetch_ra.size() != 6) $display("FAIL loop_count: got %0d fetches, expected 6", fetch_ra.size());
        else n_pass++;
        for (int i = 0; i < 6; i++) begin
            if (i < fetch_ra.size()) begin
                n_checks++;
                if (fetch_ra[i] !== exp_ra[i])
                    $display("FAIL loop_ra%0d: got RA=%h, expected %h", i, fetch_ra[i], exp_ra[i]);
                else n_pass++;
            end
        end
        n_checks++;
        if (CH_ACTIVE !== 8'h01) $display("FAIL loop_active: CH_ACTIVE=%h, expected 01", CH_ACTIVE);
        else n_pass++;
    endtask

    task automatic test_half_pitch();
        logic [23:0] exp_ra [4];
        exp_ra = '{24'h200, 24'h200, 24'h201, 24'h201};
        do_reset();
        prog_ch(1, 16'h0800, 24'h000200, 24'h000000, 24'h000FFF, 8'h00);
        wr_reg(10'h214, 8'h02);
        repeat (4) begin pulse_tick(); wait_idle(); end
        n_checks++;
        if (fetch_ra.size() != 4) $display("FAIL half_count: got %0d fetches, expected 4", fetch_ra.size());
        else n_pass++;
        for (int i = 0; i < 4; i++) begin
            if (i < fetch_ra.size()) begin
                n_checks++;
                if (fetch_ra[i] !== exp_ra[i] || fetch_ch[i] !== 4'd1)
                    $display("FAIL half_ra%0d: got ch%0d RA=%h, expected ch1 RA=%h", i, fetch_ch[i], fetch_ra[i], exp_ra[i]);
                else n_pass++;
            end
        end
    endtask

    task automatic test_ack_stall();
        int bad;
        do_reset();
        prog_ch(0, 16'h1000, 24'h000100, 24'h000000, 24'h0001FF, 8'h00);
        wr_reg(10'h214, 8'h01);
        RA_ACK = 1'b0;
        pulse_tick();
        wait_req();
        n_checks++;
        if (RA !== 24'h100 || CH_ID !== 4'd0) $display("FAIL stall_first: RA=%h CH_ID=%0d, expected 100/0", RA, CH_ID);
        else n_pass++;
        bad = 0;
        for (int i = 0; i < 10; i++) begin
            @(negedge CLK);
            TICK = (i == 3);
            if (RA_REQ !== 1'b1 || RA !== 24'h100 || BUSY !== 1'b1) bad++;
        end
        TICK = 1'b0;
        n_checks++;
        if (bad != 0) $display("FAIL stall_hold: %0d unstable cycles, expected 0", bad);
        else n_pass++;
        n_checks++;
        if (OVR !== 1'b1) $display("FAIL stall_ovr: OVR=%b, expected 1", OVR);
        else n_pass++;
        RA_ACK = 1'b1;
        wait_idle();
        n_checks++;
        if (fetch_ra.size() != 1) $display("FAIL stall_count: got %0d fetches, expected 1", fetch_ra.size());
        else n_pass++;
        n_checks++;
        if (OVR !== 1'b1) $display("FAIL ovr_sticky: OVR=%b, expected 1", OVR);
        else n_pass++;
    endtask

    task automatic test_key_off();
        int n2;
        do_reset();
        wr_reg(10'h214, 8'hFF);
        wr_reg(10'h215, 8'h04);
        pulse_tick();
        wait_idle();
        n_checks++;
        if (CH_ACTIVE !== 8'hFB) $display("FAIL keyoff_active: CH_ACTIVE=%h, expected FB", CH_ACTIVE);
        else n_pass++;
        n2 = 0;
        foreach (fetch_ch[i]) if (fetch_ch[i] == 4'd2) n2++;
        n_checks++;
        if (fetch_ra.size() != 7 || n2 != 0)
            $display("FAIL keyoff_fetches: got %0d fetches (%0d on ch2), expected 7 (0)", fetch_ra.size(), n2);
        else n_pass++;
    endtask

    task automatic test_reset_mid_fetch();
        logic [11:0] got;
        do_reset();
        prog_ch(0, 16'h1000, 24'h000100, 24'h000000, 24'h0001FF, 8'h00);
        wr_reg(10'h214, 8'h01);
        RA_ACK = 1'b0;
        pulse_tick();
        wait_req();
        pulse_tick();
        @(negedge CLK);
        n_checks++;
        if (OVR !== 1'b1 || CH_ACTIVE !== 8'h01) $display("FAIL pre_reset: OVR=%b CH_ACTIVE=%h, expected 1/01", OVR, CH_ACTIVE);
        else n_pass++;
        #2 RES = 1'b1;
        #1;
        got = {RA_REQ, BUSY, CH_ACTIVE, OVR, 1'b0};
        n_checks++;
        if (got !== 12'd0) $display("FAIL async_reset: REQ/BUSY/ACTIVE/OVR=%h, expected 0", got);
        else n_pass++;
        @(negedge CLK);
        @(negedge CLK);
        RES = 1'b0;
        RA_ACK = 1'b1;
        repeat (2) @(negedge CLK);
        fetch_ra.delete();
        fetch_ch.delete();
        pulse_tick();
        wait_idle();
        n_checks++;
        if (fetch_ra.size() != 0) $display("FAIL post_reset_fetch: got %0d fetches, expected 0", fetch_ra.size());
        else n_pass++;
    endtask

    initial begin
        repeat (3) @(negedge CLK);
        RES = 1'b0;
        @(negedge CLK);
        test_reset();
        test_one_shot();
        test_loop();
        test_half_pitch();
        test_ack_stall();
        test_key_off();
        test_reset_mid_fetch();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
